// File: rtl/trail_unwinder.sv
// trail_unwinder: starts a trail backtrack, consumes the undone entries, and queues their variables for the decision heap.
// The optional phase table is built only when TRAIL_UNWINDER_PHASE_SAVING_EN is defined.
module trail_unwinder #(
  parameter int MAX_VARS       = 256,
  parameter int REINSERT_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  int          DEBUG,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_level,
  output logic        bt_en,
  output logic [15:0] bt_level,
  input  logic        bt_valid,
  input  logic [31:0] bt_var,
  input  logic        bt_value,
  input  logic        bt_is_decision,
  input  logic        bt_done,
  input  logic        assign_en,
  input  logic [31:0] assign_var,
  input  logic        assign_value,
  input  logic [31:0] query_var,
  output logic        query_assigned,
  output logic        query_value,
  output logic        query_phase,
  output logic        reinsert_valid,
  output logic [31:0] reinsert_var,
  input  logic        reinsert_ready,
  output logic        done,
  output logic [15:0] undone_count,
  output logic [15:0] undone_decisions,
  output logic        overflow,
  input  logic        clear_all
);

  localparam int IDXW = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1;
  localparam int NENT = 1 << IDXW;
  localparam int AW   = $clog2(REINSERT_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     bt_level_q, bt_level_d;
  logic [15:0]     count_undone_q, count_undone_d;
  logic [15:0]     count_dec_q, count_dec_d;
  logic            overflow_q, overflow_d;
  logic [NENT-1:0] assigned_q, assigned_d;
  logic [NENT-1:0] value_q, value_d;
  logic [IDXW-1:0] fifo_mem_q [REINSERT_DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     fill_q, fill_d;

  logic [IDXW-1:0] bt_idx_s;
  logic [IDXW-1:0] assign_idx_s;
  logic [IDXW-1:0] query_idx_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            write_s;
  logic            drop_s;

  assign bt_idx_s     = bt_var[IDXW-1:0];
  assign assign_idx_s = assign_var[IDXW-1:0];
  assign query_idx_s  = query_var[IDXW-1:0];

  // A pop frees the head slot before the push lands, so a full FIFO still accepts a push when popping.
  assign push_s  = (state_q == DRAIN) && bt_valid && !clear_all;
  assign pop_s   = (fill_q != '0) && reinsert_ready;
  assign full_s  = (fill_q == (AW+1)'(REINSERT_DEPTH));
  assign write_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  // Control FSM next state, latched level and saturating unwind counters.
  always_comb begin
    state_d        = state_q;
    bt_level_d     = bt_level_q;
    count_undone_d = count_undone_q;
    count_dec_d    = count_dec_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d        = ISSUE;
          bt_level_d     = req_level;
          count_undone_d = 16'd0;
          count_dec_d    = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = DRAIN;
      DRAIN: begin
        if (bt_valid) begin
          if (count_undone_q != 16'hFFFF) begin
            count_undone_d = count_undone_q + 16'd1;
          end else begin
            count_undone_d = count_undone_q;
          end
          if (bt_is_decision && (count_dec_q != 16'hFFFF)) begin
            count_dec_d = count_dec_q + 16'd1;
          end else begin
            count_dec_d = count_dec_q;
          end
        end else begin
          count_undone_d = count_undone_q;
        end
        if (bt_done) begin
          state_d = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (fill_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // clear_all keeps the counters of the interrupted unwind visible.
    if (clear_all) begin
      state_d        = IDLE;
      bt_level_d     = bt_level_q;
      count_undone_d = count_undone_q;
      count_dec_d    = count_dec_q;
    end else begin
      state_d = state_d;
    end
  end

  // Control FSM and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bt_level_q     <= 16'd0;
      count_undone_q <= 16'd0;
      count_dec_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      bt_level_q     <= bt_level_d;
      count_undone_q <= count_undone_d;
      count_dec_q    <= count_dec_d;
    end
  end

  // Assignment table: a backtrack clear of the same index beats a concurrent assignment.
  always_comb begin
    assigned_d = assigned_q;
    value_d    = value_q;
    if (clear_all) begin
      assigned_d = '0;
    end else begin
      if (assign_en) begin
        assigned_d[assign_idx_s] = 1'b1;
        value_d[assign_idx_s]    = assign_value;
      end else begin
        value_d = value_q;
      end
      if (push_s) begin
        assigned_d[bt_idx_s] = 1'b0;
      end else begin
        value_d = value_d;
      end
    end
  end

  // Assignment table registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      assigned_q <= '0;
      value_q    <= '0;
    end else begin
      assigned_q <= assigned_d;
      value_q    <= value_d;
    end
  end

  // Reinsert FIFO pointers, fill level and sticky overflow.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    if (clear_all) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (write_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({write_s, pop_s})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: fill_d = fill_q;
      endcase
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Reinsert FIFO storage and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < REINSERT_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      if (write_s) begin
        fifo_mem_q[wr_ptr_q] <= bt_idx_s;
      end
    end
  end

`ifdef TRAIL_UNWINDER_PHASE_SAVING_EN
  logic [NENT-1:0] phase_q, phase_d;
  logic            unused_s;

  // Phase table: remember the polarity of every undone entry.
  always_comb begin
    phase_d = phase_q;
    if (push_s) begin
      phase_d[bt_idx_s] = bt_value;
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase table registers; clear_all leaves saved phases intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign query_phase = phase_q[query_idx_s];
  assign unused_s    = ^{DEBUG, bt_var[31:IDXW], assign_var[31:IDXW], query_var[31:IDXW]};
`else
  logic unused_s;
  assign query_phase = 1'b0;
  assign unused_s    = ^{DEBUG, bt_value, bt_var[31:IDXW], assign_var[31:IDXW], query_var[31:IDXW]};
`endif

  assign req_ready        = (state_q == IDLE);
  assign bt_en            = (state_q == ISSUE);
  assign done             = (state_q == DONE);
  assign bt_level         = bt_level_q;
  assign undone_count     = count_undone_q;
  assign undone_decisions = count_dec_q;
  assign overflow         = overflow_q;
  assign query_assigned   = assigned_q[query_idx_s];
  assign query_value      = value_q[query_idx_s];
  assign reinsert_valid   = (fill_q != '0);
  assign reinsert_var     = {{(32-IDXW){1'b0}}, fifo_mem_q[rd_ptr_q]};

endmodule

// File: doc/trail_unwinder.md
# trail_unwinder

Initiator and consumer for the trail manager's backtrack protocol. Accepts a backtrack request from the solver control FSM and issues a one-cycle `bt_en` to the trail. It consumes the streamed `bt_valid` entries, clears each variable in the assignment table, saves its phase, and buffers it for reinsertion into the decision heap. It sits between solver control, the trail manager and the VSIDS heap, and also owns the combinational assignment and phase lookup used by propagation.

## Interface
Parameters:
- `MAX_VARS`, 256, number of tracked variables; variable index is `var[$clog2(MAX_VARS)-1:0]`, upper bits ignored.
- `REINSERT_DEPTH`, 256, reinsert FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `DEBUG`  in  int  debug verbosity; 0 means silent.
- `req_valid`  in  1  backtrack request.
- `req_ready`  out  1  high only in IDLE.
- `req_level`  in  16  target decision level.
- `bt_en`  out  1  one-cycle pulse to the trail.
- `bt_level`  out  16  target level, held while busy.
- `bt_valid`  in  1  trail is emitting an undone entry.
- `bt_var`  in  32  variable of the undone entry.
- `bt_value`  in  1  value of the undone entry.
- `bt_is_decision`  in  1  undone entry was a decision.
- `bt_done`  in  1  trail completed the backtrack.
- `assign_en`  in  1  record an assignment; mirrors the trail push.
- `assign_var`  in  32  variable being assigned.
- `assign_value`  in  1  value being assigned.
- `query_var`  in  32  lookup variable.
- `query_assigned`  out  1  combinational; variable is currently assigned.
- `query_value`  out  1  combinational; current value.
- `query_phase`  out  1  combinational; saved phase.
- `reinsert_valid`  out  1  FIFO not empty.
- `reinsert_var`  out  32  FIFO head, zero-extended.
- `reinsert_ready`  in  1  heap accepts the head.
- `done`  out  1  one-cycle pulse when unwind is complete.
- `undone_count`  out  16  entries undone in the last unwind.
- `undone_decisions`  out  16  decisions undone in the last unwind.
- `overflow`  out  1  sticky flag; reinsert entry dropped.
- `clear_all`  in  1  synchronous clear.

## Operation
- States:
  - IDLE
  - ISSUE
  - DRAIN
  - FLUSH
  - DONE
- IDLE: on `req_valid`, latch `req_level` into `bt_level`, zero both counters, and go to ISSUE.
- ISSUE: assert `bt_en` for one cycle, then go to DRAIN.
- DRAIN: on each cycle with `bt_valid`:
  - clear the assigned bit for `bt_var`;
  - write `bt_value` to its phase entry;
  - push `bt_var` into the FIFO;
  - increment `undone_count`, and increment `undone_decisions` if `bt_is_decision`.
  - On `bt_done`, go to FLUSH. `bt_valid` and `bt_done` in the same cycle are both honoured.
- FLUSH: wait for the FIFO to empty, then go to DONE.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Reinsert FIFO: a pop occurs when `reinsert_valid && reinsert_ready`. Push and pop in the same cycle are allowed, including when the FIFO is full, because the pop frees the slot first.
- Overflow: a push into a full FIFO with no concurrent pop drops the entry and sets `overflow`. `overflow` clears only on `reset` or `clear_all`.
- `assign_en` is accepted in any state and sets the assigned bit and value. If it targets the same index as a `bt_valid` clear in the same cycle, the clear wins.
- Queries read registered tables only; there is no same-cycle bypass.
- Counters saturate at 16'hFFFF.
- `clear_all` takes priority over everything:
  - clears assigned bits, the FIFO and `overflow`;
  - returns the FSM to IDLE;
  - retains saved phases and counters.
- Reset values:
  - all outputs are 0;
  - FSM is in IDLE, with `req_ready` = 1;
  - all tables and the FIFO are empty or zero;
  - saved phases are 0.

## Timing
- Request accepted at cycle t; `bt_en` is high at t+1.
- The trail emits entries from t+2, one per cycle.
- Each undone entry becomes visible on `query_assigned` one cycle after its `bt_valid` cycle.
- FIFO latency: an entry pushed at cycle c can be popped at c+1.
- `done` asserts no earlier than one cycle after FLUSH is entered with an empty FIFO. With zero undone entries, `done` is at t+4 minimum (trail `bt_done` at t+2).
- `req_ready` is low from t+1 until the cycle after `done`.
- An asynchronous `reset` mid-unwind returns everything to reset values immediately, with no `done` pulse.

## Configuration
- `TRAIL_UNWINDER_PHASE_SAVING_EN`
- Defined: the phase table is implemented and updated on each undone entry; `query_phase` returns the saved value.
- Undefined: no phase table is built and `query_phase` is constant 0 (negative-polarity default). All other behaviour is identical.

## Test plan
- **Basic unwind:** assign vars 1, 2, 3 (values 1, 0, 1); request level 0; trail streams vars 3, 2, 1 with var 1 as a decision, then `bt_done`.
  - `bt_en` at t+1.
  - `query_assigned(2)` = 0.
  - FIFO pops in order 3, 2, 1.
  - `undone_count` = 3, `undone_decisions` = 1.
  - Exactly one `done` pulse.
- **Phase saving:** same as basic unwind; `query_phase(1)` = 1 and `query_phase(2)` = 0 with the macro defined; 0 for both when undefined.
- **Backpressure:** hold `reinsert_ready` = 0 during a 5-entry unwind.
  - FSM waits in FLUSH.
  - `done` comes only after 5 pops once ready is raised.
  - `overflow` = 0.
- **Overflow:** `REINSERT_DEPTH` = 2, `reinsert_ready` = 0, 3 undone entries → `overflow` = 1 and the third var is dropped; `clear_all` → `overflow` = 0.
- **Same-cycle conflict:** `assign_en` of var 7 in the same cycle as `bt_valid` for var 7 → `query_assigned(7)` = 0.
- **Mid-operation abort:** `reset` asserted during DRAIN → `req_ready` = 1, FIFO empty, no `done`; a `clear_all` during DRAIN likewise returns the FSM to IDLE.
